// File: rtl/bus_drive_arbiter.sv
// Round-robin owner sequencer for a bank of tri-state bus buffers, with guaranteed
// all-disabled turnaround between owners. Optional forced release: BUS_ARB_TIMEOUT_EN.
module bus_drive_arbiter #(
    parameter int unsigned REQUESTERS = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned HOLD_MAX   = 8
) (
    input  logic                          Clk,
    input  logic                          Clear_bar,
    input  logic [REQUESTERS-1:0]         Req,
    output logic [REQUESTERS-1:0]         Enable,
    output logic [REQUESTERS-1:0]         Grant,
    output logic [$clog2(REQUESTERS)-1:0] Owner,
    output logic                          Busy,
    output logic                          Preempt
);

    localparam int unsigned OW = $clog2(REQUESTERS);

    generate
        if (REQUESTERS < 2 || REQUESTERS > 8) begin : g_bad_requesters
            $error("bus_drive_arbiter: REQUESTERS must be in 2..8");
        end
        if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turnaround
            $error("bus_drive_arbiter: TURNAROUND must be in 1..15");
        end
        if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
            $error("bus_drive_arbiter: HOLD_MAX must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic [OW-1:0]           last_owner, last_owner_n;
    logic [OW-1:0]           owner_n;
    logic [REQUESTERS-1:0]   grant_n, enable_n;
    logic                    busy_n;
    logic [OW-1:0]           win_idle, win_rel;
    logic                    own_req, other_req;
    logic                    release_bus, release_forced;

    // First asserted request scanning upward from last+1, wrapping.
    function automatic logic [OW-1:0] rr_pick(input logic [REQUESTERS-1:0] req,
                                              input logic [OW-1:0]         last);
        logic [OW-1:0] win;
        logic          found;
        int unsigned   idx;
        win   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= REQUESTERS; k++) begin
            idx = (32'(last) + k) % REQUESTERS;
            if (!found && req[idx]) begin
                win   = OW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [REQUESTERS-1:0] onehot(input logic [OW-1:0] idx);
        logic [REQUESTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign win_idle  = rr_pick(Req, last_owner);
    assign win_rel   = rr_pick(Req, Owner);
    assign own_req   = |(Req & Grant);
    assign other_req = |(Req & ~Grant);

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold, hold_n;
    logic       preempt_n;
`endif

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        last_owner_n   = last_owner;
        owner_n        = Owner;
        grant_n        = Grant;
        enable_n       = '0;
        busy_n         = 1'b0;
        release_bus    = 1'b0;
        release_forced = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_n         = hold;
        preempt_n      = 1'b0;
`endif
        case (state)
            IDLE: begin
                owner_n = '0;
                grant_n = '0;
                if (|Req) begin
                    state_n = TURN;
                    owner_n = win_idle;
                    grant_n = onehot(win_idle);
                    cnt_n   = 4'(TURNAROUND);
                end
            end
            TURN: begin
                if (!own_req) begin
                    // abandoned before driving: last_owner intentionally untouched
                    state_n = IDLE;
                    owner_n = '0;
                    grant_n = '0;
                    cnt_n   = '0;
                end else if (cnt == 4'd1) begin
                    state_n  = OWN;
                    enable_n = Grant;
                    busy_n   = 1'b1;
                    cnt_n    = '0;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_n   = 8'd1;
`endif
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            OWN: begin
                release_bus = !own_req;
`ifdef BUS_ARB_TIMEOUT_EN
                release_forced = own_req && other_req && (hold == 8'(HOLD_MAX));
                preempt_n      = release_forced;
`endif
                if (release_bus || release_forced) begin
                    last_owner_n = Owner;
                    if (other_req) begin
                        state_n = TURN;
                        owner_n = win_rel;
                        grant_n = onehot(win_rel);
                        cnt_n   = 4'(TURNAROUND);
                    end else begin
                        state_n = IDLE;
                        owner_n = '0;
                        grant_n = '0;
                    end
                end else begin
                    enable_n = Grant;
                    busy_n   = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                    if (hold != 8'(HOLD_MAX)) hold_n = hold + 8'd1;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                owner_n = '0;
                grant_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= OW'(REQUESTERS - 1);
            Owner      <= '0;
            Grant      <= '0;
            Enable     <= '0;
            Busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_owner <= last_owner_n;
            Owner      <= owner_n;
            Grant      <= grant_n;
            Enable     <= enable_n;
            Busy       <= busy_n;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            hold    <= '0;
            Preempt <= 1'b0;
        end else begin
            hold    <= hold_n;
            Preempt <= preempt_n;
        end
    end
`else
    assign Preempt = 1'b0;
`endif

endmodule

// File: doc/bus_drive_arbiter.md
Name: bus_drive_arbiter

Overview:
- Sequences the output-enable (C) lines of a bank of positive-enable tri-state bus buffers that share one bus.
- Arbitrates round-robin among REQUESTERS sources and grants one at a time.
- Guarantees TURNAROUND all-disabled cycles between any two bus owners, so no two buffers ever drive the bus at once.
- Sits between the microsequencer/peripheral request lines and the buffer enable pins.

Parameters:
REQUESTERS, 4, number of bus sources/buffers; legal range 2..8.
TURNAROUND, 1, dead cycles with all enables low before a new owner drives; legal range 1..15.
HOLD_MAX, 8, max OWN cycles before forced release; used only with the optional feature; legal range 1..255.

Ports:
Clk  input  1  rising-edge clock.
Clear_bar  input  1  asynchronous active-low reset.
Req  input  REQUESTERS  per-source request; held high for as long as the source wants the bus.
Enable  output  REQUESTERS  one-hot-or-zero; drives the buffer C inputs; high only in OWN.
Grant  output  REQUESTERS  one-hot-or-zero; selected source, valid in TURN and OWN.
Owner  output  clog2(REQUESTERS)  index of the granted source; 0 when no source is granted.
Busy  output  1  high while in OWN.
Preempt  output  1  one-cycle pulse on forced release; tied 0 without the optional feature.

Behaviour:
- Reset and clocking:
  - One clock. Reset is asynchronous and active-low: Clear_bar low forces reset immediately, independent of Clk.
  - All outputs are registered.
  - Reset values: Enable=0, Grant=0, Owner=0, Busy=0, Preempt=0, state=IDLE, counter=0, last_owner=REQUESTERS-1 (so source 0 has first priority).
  - Clear_bar low mid-OWN drops Enable the same instant (asynchronous); no bus hold-over.
- Round-robin select: the winner is the first asserted Req scanning upward from last_owner+1, wrapping modulo REQUESTERS.
- IDLE:
  - Enable=0, Grant=0.
  - Any Req high -> TURN next cycle, with Grant/Owner=winner and counter=TURNAROUND.
- TURN:
  - Enable=0, Grant held.
  - Counter decrements each cycle. Counter==1 with Req[Owner] still high -> OWN next cycle (Enable=Grant, Busy=1).
  - Req[Owner] low during TURN -> IDLE next cycle. The request is abandoned and last_owner is unchanged.
- OWN:
  - Enable=Grant, Busy=1.
  - Req[Owner] low -> next cycle Enable=0, Busy=0, last_owner=Owner.
    - If another Req is high: go to TURN with the new winner (computed from the updated last_owner) and counter=TURNAROUND.
    - Otherwise: go to IDLE.
  - The same source re-requesting immediately is handled like any other source: round-robin order, full turnaround.
- Latency:
  - Req rise to Enable: 1+TURNAROUND cycles from IDLE.
  - Req fall to Enable fall: 1 cycle.
  - Owner-to-owner dead time: exactly TURNAROUND cycles.
- Simultaneous events: multiple Req rising in the same cycle resolve by round-robin only; Req changes of non-granted sources have no effect until the next arbitration point.
- Invariants:
  - popcount(Enable) <= 1 in every cycle.
  - Enable != 0 only in OWN.
  - Enable is never nonzero in two consecutive cycles for different sources.
- Illegal parameter values are a compile-time error (generate-time check).

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter counts OWN cycles.
  - When it reaches HOLD_MAX while any other Req is high, the owner is forcibly released: next cycle Enable=0, Busy=0, Preempt=1 for exactly one cycle.
  - last_owner=Owner; go to TURN with the next winner.
  - If no other Req is pending, the counter saturates and the owner keeps the bus.
  - The preempted source's still-high Req is re-arbitrated in normal round-robin order.
- Undefined: no hold counter; an owner keeps the bus indefinitely; Preempt constant 0.

Test Plan:
- Reset then Req=4'b0001, TURNAROUND=2 -> Grant=0001 at cycle 1, Enable=0001 at cycle 3, Busy=1, Owner=0.
- Req=4'b1111 held, each owner drops its Req after 3 OWN cycles and re-raises it -> owners 0,1,2,3,0; exactly 2 cycles of Enable=0 between owners; popcount(Enable)<=1 throughout.
- Owner 2 in OWN, Clear_bar pulsed low between clock edges -> Enable=0 immediately; after release, Req=0100 re-granted with first priority to source 0 if it is also requesting.
- Req=0010 raised then dropped during TURN -> returns to IDLE, Enable never nonzero, next Req=0011 grants source 0 (last_owner unchanged at 3).
- With BUS_ARB_TIMEOUT_EN, HOLD_MAX=8, Req=0011 held continuously -> source 0 owns 8 cycles, Preempt pulses once, source 1 enabled after TURNAROUND, then alternates.
- Without BUS_ARB_TIMEOUT_EN, same stimulus -> source 0 holds Enable=0001 for 100 cycles, Preempt stays 0.
